// File: rtl/sbus_read_requester_if.sv
// Request, SBUS master-side and response signals of the MBOX read requester.
interface sbus_read_requester_if;
    logic         req_valid;
    logic         req_ready;
    logic [12:35] req_adr;
    logic [0:3]   req_rq;
    logic         req_port;
    logic         START_A;
    logic         START_B;
    logic [0:3]   RQ;
    logic [12:35] ADR;
    logic         DATA_VALID_A;
    logic         DATA_VALID_B;
    logic [0:35]  D;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [0:35]  rsp_data;
    logic [12:35] rsp_adr;
    logic         rsp_last;
    logic         rsp_err;

    modport master (
        input  req_valid, req_adr, req_rq, req_port,
        input  DATA_VALID_A, DATA_VALID_B, D, rsp_ready,
        output req_ready, START_A, START_B, RQ, ADR,
        output rsp_valid, rsp_data, rsp_adr, rsp_last, rsp_err
    );

    modport slave (
        output req_valid, req_adr, req_rq, req_port,
        output DATA_VALID_A, DATA_VALID_B, D, rsp_ready,
        input  req_ready, START_A, START_B, RQ, ADR,
        input  rsp_valid, rsp_data, rsp_adr, rsp_last, rsp_err
    );
endinterface

// File: rtl/sbus_read_requester.sv
// SBUS quadword read sequencer: issues START, captures strobed words,
// then drains them to the cache-fill consumer one beat at a time.
module sbus_read_requester #(
    parameter int START_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    sbus_read_requester_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(START_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, DRAIN, ERR} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   dv_a_q;
    logic                   dv_b_q;
    logic                   ev_a;
    logic                   ev_b;
    logic                   ev;

    logic [12:35] lat_adr;
    logic [0:3]   remain;
    logic         lat_port;
    logic [2:0]   expected;
    logic [2:0]   k;
    logic [1:0]   rd;
    logic [1:0]   nxt_i;
    logic [TW-1:0] timer;
    logic [SW-1:0] scnt;
    logic [0:35]  buf_data [4];
    logic [12:35] buf_adr  [4];

    function automatic logic [2:0] popcnt(input logic [0:3] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Strobes are asynchronous: synchronize, then keep one event per rise.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a <= '0;
            sync_b <= '0;
            dv_a_q <= 1'b0;
            dv_b_q <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.DATA_VALID_A};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.DATA_VALID_B};
            dv_a_q <= sync_a[SYNC_STAGES-1];
            dv_b_q <= sync_b[SYNC_STAGES-1];
        end
    end

    assign ev_a = sync_a[SYNC_STAGES-1] & ~dv_a_q;
    assign ev_b = sync_b[SYNC_STAGES-1] & ~dv_b_q;
    assign ev   = lat_port ? ev_b : ev_a;

    // Lowest-numbered requested word not yet returned.
    always_comb begin
        nxt_i = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (remain[i]) nxt_i = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            bus.req_ready <= 1'b0;
            bus.START_A   <= 1'b0;
            bus.START_B   <= 1'b0;
            bus.RQ        <= '0;
            bus.ADR       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_adr   <= '0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            lat_adr       <= '0;
            remain        <= '0;
            lat_port      <= 1'b0;
            expected      <= '0;
            k             <= '0;
            rd            <= '0;
            timer         <= '0;
            scnt          <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_data[i] <= '0;
                buf_adr[i]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        lat_adr       <= bus.req_adr;
                        remain        <= bus.req_rq;
                        lat_port      <= bus.req_port;
                        expected      <= popcnt(bus.req_rq);
                        k             <= '0;
                        rd            <= '0;
                        if (bus.req_rq == 4'b0000) begin
                            state         <= ERR;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_last  <= 1'b1;
                            bus.rsp_data  <= '0;
                            bus.rsp_adr   <= bus.req_adr;
                        end else begin
                            state       <= START;
                            bus.START_A <= ~bus.req_port;
                            bus.START_B <= bus.req_port;
                            bus.RQ      <= bus.req_rq;
                            bus.ADR     <= bus.req_adr;
                            scnt        <= SW'(START_CYCLES - 1);
                        end
                    end
                end
                START: begin
                    if (scnt == '0) begin
                        bus.START_A <= 1'b0;
                        bus.START_B <= 1'b0;
                        timer       <= TW'(TIMEOUT_CYCLES - 1);
                        state       <= WAIT;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (ev) begin
                        buf_data[k[1:0]] <= bus.D;
                        buf_adr[k[1:0]]  <= lat_adr + 24'(nxt_i);
                        remain[nxt_i]    <= 1'b0;
                        k                <= k + 3'd1;
                        timer            <= TW'(TIMEOUT_CYCLES - 1);
                        if (k + 3'd1 == expected) state <= DRAIN;
                    end else if (timer == '0) begin
                        state         <= ERR;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_last  <= 1'b1;
                        bus.rsp_data  <= '0;
                        bus.rsp_adr   <= lat_adr;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DRAIN: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= buf_data[rd];
                        bus.rsp_adr   <= buf_adr[rd];
                        bus.rsp_last  <= ({1'b0, rd} == k - 3'd1);
                    end else if (bus.rsp_ready) begin
                        if (bus.rsp_last) begin
                            state         <= IDLE;
                            bus.req_ready <= 1'b1;
                            bus.rsp_valid <= 1'b0;
                            bus.rsp_last  <= 1'b0;
                            bus.rsp_data  <= '0;
                            bus.rsp_adr   <= '0;
                            bus.RQ        <= '0;
                            bus.ADR       <= '0;
                        end else begin
                            rd           <= rd + 2'd1;
                            bus.rsp_data <= buf_data[rd + 2'd1];
                            bus.rsp_adr  <= buf_adr[rd + 2'd1];
                            bus.rsp_last <= ({1'b0, rd + 2'd1} == k - 3'd1);
                        end
                    end
                end
                ERR: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_last  <= 1'b0;
                        bus.rsp_adr   <= '0;
                        bus.RQ        <= '0;
                        bus.ADR       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbus_read_requester.sv
// Directed bench for sbus_read_requester with a response scoreboard.
module tb_sbus_read_requester;
    localparam int TO = 64;

    typedef struct {
        logic [0:35]  data;
        logic [12:35] adr;
        logic         last;
        logic         err;
    } beat_t;

    logic clk = 1'b0;
    logic RESET_N;
    always #5 clk = ~clk;

    sbus_read_requester_if bus ();

    sbus_read_requester #(
        .START_CYCLES(2),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    beat_t       sb [$];
    logic [0:35] wd [4];
    int          errors = 0;
    int          checks = 0;
    int          fv;
    int          cyc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [12:35] adr, input logic [0:3] rq);
        int n;
        int tot;
        beat_t b;
        n = 0;
        tot = $countones(rq);
        for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
                b.data = wd[n];
                b.adr  = adr + 24'(i);
                b.last = (n == tot - 1);
                b.err  = 1'b0;
                sb.push_back(b);
                n++;
            end
        end
    endtask

    task automatic push_err(input logic [12:35] adr);
        beat_t b;
        b.data = '0;
        b.adr  = adr;
        b.last = 1'b1;
        b.err  = 1'b1;
        sb.push_back(b);
    endtask

    task automatic issue(input logic [12:35] adr, input logic [0:3] rq,
                         input logic port, input bit do_start);
        int w;
        int na;
        int nb;
        bus.req_adr   = adr;
        bus.req_rq    = rq;
        bus.req_port  = port;
        bus.req_valid = 1'b1;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", 64'(w < 50), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready_busy", bus.req_ready, 0);
        if (do_start) begin
            chk("rq_out", bus.RQ, rq);
            chk("adr_out", bus.ADR, adr);
            na = 0;
            nb = 0;
            for (int i = 0; i < 8; i++) begin
                na += int'(bus.START_A);
                nb += int'(bus.START_B);
                @(negedge clk);
            end
            chk("start_a_cycles", na, port ? 0 : 2);
            chk("start_b_cycles", nb, port ? 2 : 0);
        end
    endtask

    task automatic strobe(input logic port, input logic [0:35] data,
                          output int first_valid);
        first_valid = 0;
        bus.D = data;
        if (port) bus.DATA_VALID_B = 1'b1;
        else      bus.DATA_VALID_A = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && first_valid == 0) first_valid = i;
            if (i == 4) begin
                bus.DATA_VALID_A = 1'b0;
                bus.DATA_VALID_B = 1'b0;
            end
        end
    endtask

    task automatic get_beats(input int n, input int bp);
        int w;
        beat_t e;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (bus.rsp_valid !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("rsp_valid_wait", 64'(w < 200), 1);
            e = sb.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_adr", bus.rsp_adr, e.adr);
            chk("rsp_last", bus.rsp_last, e.last);
            chk("rsp_err", bus.rsp_err, e.err);
            if (b == bp) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("bp_valid", bus.rsp_valid, 1);
                    chk("bp_data", bus.rsp_data, e.data);
                    chk("bp_adr", bus.rsp_adr, e.adr);
                end
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            chk("no_extra_beat", bus.rsp_valid, 0);
            @(negedge clk);
        end
        chk("sb_drained", sb.size(), 0);
        chk("req_ready_idle", bus.req_ready, 1);
    endtask

    initial begin
        RESET_N          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_adr      = '0;
        bus.req_rq       = '0;
        bus.req_port     = 1'b0;
        bus.DATA_VALID_A = 1'b0;
        bus.DATA_VALID_B = 1'b0;
        bus.D            = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_start_a", bus.START_A, 0);
        chk("rst_start_b", bus.START_B, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rq_adr", {bus.RQ, bus.ADR}, 0);
        chk("rst_rsp_flags", {bus.rsp_last, bus.rsp_err}, 0);
        RESET_N = 1'b1;
        #1;
        chk("req_ready_before_clk", bus.req_ready, 0);
        @(negedge clk);
        chk("req_ready_after_clk", bus.req_ready, 1);

        // Full mask, port A
        for (int j = 0; j < 4; j++) wd[j] = 36'(j + 1);
        push_words(24'o00001000, 4'b1111);
        issue(24'o00001000, 4'b1111, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) strobe(1'b0, wd[j], fv);
        chk("last_edge_latency", fv, 4);
        get_beats(4, -1);

        // Sparse mask, port B, address wrap; a port A strobe must be ignored
        wd[0] = 36'o111;
        wd[1] = 36'o222;
        push_words(24'o77777776, 4'b0101);
        issue(24'o77777776, 4'b0101, 1'b1, 1'b1);
        strobe(1'b0, 36'o777, fv);
        chk("other_port_ignored", bus.rsp_valid, 0);
        strobe(1'b1, wd[0], fv);
        strobe(1'b1, wd[1], fv);
        get_beats(2, -1);

        // Backpressure on beat 2
        for (int j = 0; j < 4; j++) wd[j] = 36'({$urandom, $urandom});
        push_words(24'o00004321, 4'b1111);
        issue(24'o00004321, 4'b1111, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) strobe(1'b0, wd[j], fv);
        get_beats(4, 1);

        // Timeout after two of four words
        issue(24'o00002000, 4'b1111, 1'b0, 1'b1);
        strobe(1'b0, 36'o1, fv);
        strobe(1'b0, 36'o2, fv);
        cyc = 8;
        while (bus.rsp_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_window", 64'(cyc >= TO && cyc <= TO + 4), 1);
        push_err(24'o00002000);
        get_beats(1, -1);

        // Empty mask
        issue(24'o00000555, 4'b0000, 1'b0, 1'b0);
        chk("empty_err_next_cycle", bus.rsp_valid, 1);
        chk("empty_no_start", {bus.START_A, bus.START_B}, 0);
        push_err(24'o00000555);
        get_beats(1, -1);

        // Reset in WAIT after one word
        issue(24'o00003000, 4'b1111, 1'b0, 1'b1);
        strobe(1'b0, 36'o12345, fv);
        RESET_N = 1'b0;
        #1;
        chk("midrst_start", {bus.START_A, bus.START_B}, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(negedge clk);
        wd[0] = 36'o765432;
        push_words(24'o00006000, 4'b1000);
        issue(24'o00006000, 4'b1000, 1'b1, 1'b1);
        strobe(1'b1, wd[0], fv);
        chk("single_word_latency", fv, 4);
        get_beats(1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
